// File: rtl/scoreboard_register_file.sv
// Register file with a pending-write scoreboard. Reads are combinational with
// optional same-cycle write forwarding; busy bits track issued-but-unwritten destinations.
module scoreboard_register_file #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREAD*AW-1:0]     rs,
    output logic [NREAD*XLEN-1:0]   rdata,
    output logic [NREAD-1:0]        rs_ready,
    input  logic [NWRITE-1:0]       we,
    input  logic [NWRITE*AW-1:0]    wa,
    input  logic [NWRITE*XLEN-1:0]  wd,
    input  logic                    issue_valid,
    input  logic [AW-1:0]           issue_rd,
    output logic [NREGS-1:0]        busy,
    output logic [AW:0]             busy_count
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy_nxt;
    logic [AW:0]      count_nxt;

    // Writes clear first, then an issue to the same register re-sets the bit.
    always_comb begin
        busy_nxt = busy;
        for (int j = 0; j < NWRITE; j++) begin
            if (we[j] && wa[j*AW +: AW] != '0)
                busy_nxt[wa[j*AW +: AW]] = 1'b0;
        end
        if (issue_valid && issue_rd != '0)
            busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
        count_nxt = '0;
        for (int i = 0; i < NREGS; i++)
            count_nxt = count_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy       <= '0;
            busy_count <= '0;
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            busy       <= busy_nxt;
            busy_count <= count_nxt;
            // Ascending port order so the highest-index port wins a collision.
            for (int j = 0; j < NWRITE; j++) begin
                if (we[j] && wa[j*AW +: AW] != '0)
                    regs[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
            end
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] val;
        logic            hit;
        logic [XLEN-1:0] rd_val;
        logic            rd_rdy;

        always_comb begin
            ra  = rs[k*AW +: AW];
            val = regs[ra];
            hit = 1'b0;
            if (BYPASS != 0) begin
                for (int j = 0; j < NWRITE; j++) begin
                    if (we[j] && wa[j*AW +: AW] == ra) begin
                        val = wd[j*XLEN +: XLEN];
                        hit = 1'b1;
                    end
                end
            end
            if (reset || ra == '0) begin
                rd_val = '0;
                rd_rdy = 1'b1;
            end else begin
                rd_val = val;
                rd_rdy = !busy[ra] || hit;
            end
        end

        assign rdata[k*XLEN +: XLEN] = rd_val;
        assign rs_ready[k]           = rd_rdy;
    end

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Drives a bypassing and a non-bypassing instance with the same stimulus and
// compares both against an array-based model of the register file and scoreboard.
module tb_scoreboard_register_file;
    localparam int XLEN = 32, NREGS = 32, AW = 5, NREAD = 2, NWRITE = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREAD*AW-1:0]    rs;
    logic [NWRITE-1:0]      we;
    logic [NWRITE*AW-1:0]   wa;
    logic [NWRITE*XLEN-1:0] wd;
    logic                   issue_valid;
    logic [AW-1:0]          issue_rd;

    logic [NREAD*XLEN-1:0] rdata_a, rdata_b;
    logic [NREAD-1:0]      rdy_a, rdy_b;
    logic [NREGS-1:0]      busy_a, busy_b;
    logic [AW:0]           cnt_a, cnt_b;

    logic [XLEN-1:0]  m_regs [NREGS];
    logic [NREGS-1:0] m_busy;
    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    scoreboard_register_file #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .rs(rs), .rdata(rdata_a), .rs_ready(rdy_a),
        .we(we), .wa(wa), .wd(wd), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .busy(busy_a), .busy_count(cnt_a));

    scoreboard_register_file #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .rs(rs), .rdata(rdata_b), .rs_ready(rdy_b),
        .we(we), .wa(wa), .wd(wd), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .busy(busy_b), .busy_count(cnt_b));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic idle();
        we = '0; wa = '0; wd = '0; issue_valid = 1'b0; issue_rd = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        m_busy = '0;
    endtask

    // Expected read results straight from the model contents and pending writes.
    task automatic check_reads();
        for (int k = 0; k < NREAD; k++) begin
            logic [AW-1:0]   a;
            logic [XLEN-1:0] fwd, stored;
            logic            hit;
            a = rs[k*AW +: AW];
            stored = (a == 0) ? '0 : m_regs[a];
            fwd = stored;
            hit = 1'b0;
            for (int j = 0; j < NWRITE; j++)
                if (we[j] && a != 0 && wa[j*AW +: AW] == a) begin
                    fwd = wd[j*XLEN +: XLEN];
                    hit = 1'b1;
                end
            chk($sformatf("rdata_byp%0d", k), rdata_a[k*XLEN +: XLEN], fwd);
            chk($sformatf("rdy_byp%0d", k),   rdy_a[k], (a == 0) || !m_busy[a] || hit);
            chk($sformatf("rdata_nob%0d", k), rdata_b[k*XLEN +: XLEN], stored);
            chk($sformatf("rdy_nob%0d", k),   rdy_b[k], (a == 0) || !m_busy[a]);
        end
    endtask

    task automatic update_model();
        for (int j = 0; j < NWRITE; j++)
            if (we[j] && wa[j*AW +: AW] != 0) begin
                m_regs[wa[j*AW +: AW]] = wd[j*XLEN +: XLEN];
                m_busy[wa[j*AW +: AW]] = 1'b0;
            end
        if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    endtask

    task automatic check_state();
        chk("busy_byp", busy_a, m_busy);
        chk("cnt_byp",  cnt_a,  $countones(m_busy));
        chk("busy_nob", busy_b, m_busy);
        chk("cnt_nob",  cnt_b,  $countones(m_busy));
    endtask

    // Called just after a negedge with inputs already applied.
    task automatic cycle();
        #1 check_reads();
        @(posedge clk);
        update_model();
        #1 check_state();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; rs = '0; idle(); model_clear();
        #1;
        chk("rst_busy", busy_a, 0);
        chk("rst_cnt",  cnt_a, 0);
        chk("rst_rdy",  rdy_a, 2'b11);
        @(negedge clk) reset = 1'b0;

        // x0 is never written nor marked busy
        we = 2'b01; wa = '0; wd = 64'h1234; issue_valid = 1'b1; issue_rd = '0; rs = '0;
        cycle();
        chk("x0_data", rdata_a[31:0], 0);
        chk("x0_busy", busy_a[0], 0);
        chk("x0_cnt",  cnt_a, 0);

        idle(); we = 2'b01; wa = 10'd5; wd = 64'hDEADBEEF;
        cycle();
        idle(); rs = {5'd0, 5'd5};
        #1 chk("x5_data", rdata_a[31:0], 32'hDEADBEEF);
        chk("x5_rdy", rdy_a[0], 1);
        cycle();

        idle(); issue_valid = 1'b1; issue_rd = 5'd7;
        cycle();
        idle(); rs = {5'd7, 5'd0};
        #1 chk("x7_notrdy", rdy_a[1], 0);
        chk("x7_cnt", cnt_a, 1);
        we = 2'b01; wa = 10'd7; wd = 64'h55;
        #1 chk("x7_fwd", rdata_a[63:32], 32'h55);
        chk("x7_fwd_rdy", rdy_a[1], 1);
        chk("x7_nob_rdy", rdy_b[1], 0);
        cycle();
        chk("x7_cleared", busy_a[7], 0);

        idle(); we = 2'b11; wa = {5'd3, 5'd3}; wd = {32'h22, 32'h11};
        cycle();
        idle(); rs = {5'd0, 5'd3};
        #1 chk("x3_hiwins", rdata_a[31:0], 32'h22);
        issue_valid = 1'b1; issue_rd = 5'd9; we = 2'b01; wa = 10'd9; wd = 64'h99;
        cycle();
        chk("x9_issuewins", busy_a[9], 1);

        idle(); we = 2'b01; wa = 10'd2; wd = 64'hAA; rs = {5'd0, 5'd2};
        #1 chk("x2_nob_old", rdata_b[31:0], 0);
        cycle();
        chk("x2_nob_new", rdata_b[31:0], 32'hAA);

        // Issue x1..x4, then async reset between edges
        for (int r = 1; r <= 4; r++) begin
            idle(); issue_valid = 1'b1; issue_rd = AW'(r);
            cycle();
        end
        idle(); rs = {5'd3, 5'd5};
        @(posedge clk); update_model();
        #3 reset = 1'b1;
        #1 chk("ar_busy", busy_a, 0);
        chk("ar_cnt", cnt_a, 0);
        chk("ar_rdata", rdata_a, 0);
        chk("ar_rdy", rdy_a, 2'b11);
        chk("ar_nob_busy", busy_b, 0);
        @(negedge clk);
        we = 2'b11; wa = {5'd6, 5'd8}; wd = {32'h1, 32'h2}; issue_valid = 1'b1; issue_rd = 5'd10;
        @(posedge clk); #1 chk("ar_hold_busy", busy_a, 0);
        @(negedge clk); idle(); reset = 1'b0; model_clear();
        cycle();
        chk("ar_regs_zero", rdata_b, 0);

        for (int n = 0; n < 400; n++) begin
            we = NWRITE'($urandom_range(0, 3));
            wa = {AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))};
            wd = {$urandom, $urandom};
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd = AW'($urandom_range(0, 15));
            rs = {AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))};
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/scoreboard_register_file.md
SCOREBOARD_REGISTER_FILE -- requirements
Module: scoreboard_register_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, data word width in bits.
REQ-002 SHALL have parameter NREGS, default 32, architectural register count, power of two, >= 2; AW = $clog2(NREGS).
REQ-003 SHALL have parameter NREAD, default 2, number of read ports, 1..4.
REQ-004 SHALL have parameter NWRITE, default 1, number of write ports, 1..2.
REQ-005 SHALL have parameter BYPASS, default 1, enabling same-cycle write-to-read forwarding when 1.
REQ-006 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-008 SHALL have port rs, input, NREAD*AW, read selects; port k uses bits [k*AW +: AW].
REQ-009 SHALL have port rdata, output, NREAD*XLEN, read data; port k uses bits [k*XLEN +: XLEN].
REQ-010 SHALL have port rs_ready, output, NREAD, per read port: operand valid this cycle.
REQ-011 SHALL have port we, input, NWRITE, per write port: write enable.
REQ-012 SHALL have port wa, input, NWRITE*AW, write addresses.
REQ-013 SHALL have port wd, input, NWRITE*XLEN, write data.
REQ-014 SHALL have port issue_valid, input, 1, marks issue_rd as pending write.
REQ-015 SHALL have port issue_rd, input, AW, destination register being issued.
REQ-016 SHALL have port busy, output, NREGS, registered pending-write bitmap; bit 0 always 0.
REQ-017 SHALL have port busy_count, output, AW+1, registered population count of busy.

Function
REQ-018 SHALL hold registers 1..NREGS-1 as XLEN-bit state; register 0 SHALL read as 0 and never be written or marked busy.
REQ-019 SHALL perform a write when we[j]=1 and wa[j]!=0, updating the register at the next rising edge.
REQ-020 SHALL, when two write ports target the same nonzero address in one cycle, store wd of the highest-index port.
REQ-021 SHALL produce rdata combinationally from current contents (zero latency).
REQ-022 SHALL, when BYPASS=1 and a read address matches an active nonzero write address, return that write's wd (highest-index port wins); when BYPASS=0 return stored contents.
REQ-023 SHALL set busy[issue_rd] at the next edge when issue_valid=1 and issue_rd!=0.
REQ-024 SHALL clear busy[wa[j]] at the next edge for every active write with wa[j]!=0, whether or not the bit was set.
REQ-025 SHALL, when an issue and a write target the same register in the same cycle, leave busy set (issue wins).
REQ-026 SHALL drive rs_ready[k]=1 when rs[k]==0, or busy[rs[k]]==0, or (BYPASS=1 and an active write matches rs[k]); else 0.
REQ-027 SHALL update busy_count in the same edge as busy, equal to the number of set bits in the new busy value.
REQ-028 SHALL treat out-of-range inputs only via the AW-bit field; no other input checks.

Reset
REQ-029 SHALL, on reset assertion, immediately clear all registers, busy and busy_count to 0, independent of clk.
REQ-030 SHALL ignore we and issue_valid while reset is asserted; the first update occurs at the first rising edge after deassertion.
REQ-031 SHALL, during reset, drive rdata=0 and rs_ready all 1 for every read port.

Verification
REQ-032 SHALL cover: write x5=0xDEADBEEF, next cycle read rs0=5 -> rdata0=0xDEADBEEF, rs_ready0=1.
REQ-033 SHALL cover: write x0=0x1234 then read rs0=0 -> rdata0=0, busy[0]=0; issue_rd=0 -> busy_count stays 0.
REQ-034 SHALL cover: issue x7, next cycle read rs1=7 -> rs_ready1=0, busy_count=1; write x7=0x55 same cycle with BYPASS=1 -> rdata1=0x55, rs_ready1=1; next cycle busy[7]=0.
REQ-035 SHALL cover: NWRITE=2, both ports write x3 (0x11 port0, 0x22 port1) -> x3=0x22; simultaneous issue x9 and write x9 -> busy[9]=1.
REQ-036 SHALL cover: issue x1..x4 over 4 cycles then assert reset mid-cycle asynchronously -> busy=0, busy_count=0, all registers 0 before next clk edge.
REQ-037 SHALL cover: BYPASS=0, write x2=0xAA while reading rs0=2 -> rdata0=old value 0 that cycle, 0xAA next cycle.
